// File: rtl/anim_sequencer.sv
// anim_sequencer: frame-tick prescaler plus idle/requested animation sequencer.
// Optional feature macro ANIM_PINGPONG_EN: the idle step bounces 0..15..0 instead of wrapping.
module anim_sequencer #(
  parameter int TICK_DIV   = 33554432,
  parameter int NUM_FRAMES = 16,
  parameter int LOOP_COUNT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_sleep,
  input  logic       req_eat,
  input  logic       req_play,
  output logic [1:0] anim_sel,
  output logic [3:0] step,
  output logic       frame_tick,
  output logic       busy,
  output logic       done
);
  localparam int PS_W   = $clog2(TICK_DIV);
  localparam int PASS_W = (LOOP_COUNT > 1) ? $clog2(LOOP_COUNT) : 1;
  localparam logic [PS_W-1:0]   PS_MAX   = PS_W'(TICK_DIV - 1);
  localparam logic [3:0]        STEP_MAX = 4'(NUM_FRAMES - 1);
  localparam logic [PASS_W-1:0] PASS_MAX = PASS_W'(LOOP_COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [PS_W-1:0]   presc_q, presc_d;
  logic [3:0]        step_q, step_d;
  logic [1:0]        sel_q, sel_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              pend_valid_q, pend_valid_d;
  logic [1:0]        pend_sel_q, pend_sel_d;
`ifdef ANIM_PINGPONG_EN
  logic              dir_down_q, dir_down_d;
`endif

  logic       tick;
  logic       any_src;
  logic       start_entry;
  logic [1:0] req_sel;
  logic [1:0] cand_sel;

  // Animation codes double as priorities: play(3) > eat(2) > sleep(1).
  always_comb begin
    req_sel = 2'd0;
    if (req_play) begin
      req_sel = 2'd3;
    end else if (req_eat) begin
      req_sel = 2'd2;
    end else if (req_sleep) begin
      req_sel = 2'd1;
    end
    cand_sel = (pend_valid_q && (pend_sel_q > req_sel)) ? pend_sel_q : req_sel;
    any_src  = (req_sel != 2'd0) || pend_valid_q;
    tick     = ((state_q == S_IDLE) || (state_q == S_RUN)) && (presc_q == PS_MAX);
  end

  always_comb begin
    state_d      = state_q;
    presc_d      = '0;
    step_d       = step_q;
    sel_d        = sel_q;
    pass_d       = pass_q;
    pend_valid_d = pend_valid_q;
    pend_sel_d   = pend_sel_q;
    start_entry  = 1'b0;
`ifdef ANIM_PINGPONG_EN
    dir_down_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        presc_d = tick ? '0 : presc_q + PS_W'(1);
        sel_d   = 2'd0;
`ifdef ANIM_PINGPONG_EN
        dir_down_d = dir_down_q;
        if (tick) begin
          if (dir_down_q) begin
            if (step_q == 4'd0) begin
              step_d     = 4'd1;
              dir_down_d = 1'b0;
            end else begin
              step_d = step_q - 4'd1;
            end
          end else if (step_q == STEP_MAX) begin
            step_d     = STEP_MAX - 4'd1;
            dir_down_d = 1'b1;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
`else
        if (tick) begin
          step_d = (step_q == STEP_MAX) ? 4'd0 : step_q + 4'd1;
        end
`endif
        start_entry = any_src;
      end
      S_START: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        presc_d = tick ? '0 : presc_q + PS_W'(1);
        // One-deep pending slot: only a strictly higher priority replaces it.
        if ((req_sel != 2'd0) && (!pend_valid_q || (req_sel > pend_sel_q))) begin
          pend_valid_d = 1'b1;
          pend_sel_d   = req_sel;
        end
        if (tick) begin
          if (step_q != STEP_MAX) begin
            step_d = step_q + 4'd1;
          end else if (pass_q != PASS_MAX) begin
            step_d = 4'd0;
            pass_d = pass_q + PASS_W'(1);
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        start_entry = any_src;
        if (!any_src) begin
          state_d = S_IDLE;
          sel_d   = 2'd0;
          step_d  = 4'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_entry) begin
      state_d = S_START;
      sel_d   = cand_sel;
      step_d  = 4'd0;
      pass_d  = '0;
      if (pend_valid_q && (pend_sel_q == cand_sel)) begin
        pend_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      step_q       <= 4'd0;
      sel_q        <= 2'd0;
      pass_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_sel_q   <= 2'd0;
`ifdef ANIM_PINGPONG_EN
      dir_down_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      step_q       <= step_d;
      sel_q        <= sel_d;
      pass_q       <= pass_d;
      pend_valid_q <= pend_valid_d;
      pend_sel_q   <= pend_sel_d;
`ifdef ANIM_PINGPONG_EN
      dir_down_q   <= dir_down_d;
`endif
    end
  end

  assign anim_sel   = sel_q;
  assign step       = step_q;
  assign frame_tick = tick;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FINISH);

endmodule

// File: tb/tb_anim_sequencer.sv
// Scoreboard bench for anim_sequencer: a timeline-based reference model queues
// the expected per-cycle outputs, and an independent monitor pops and compares.
module tb_anim_sequencer;
  localparam int T   = 4;
  localparam int N   = 16;
  localparam int L   = 2;
  localparam int NLT = N * L * T;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_sleep;
  logic       req_eat;
  logic       req_play;
  logic [1:0] anim_sel;
  logic [3:0] step;
  logic       frame_tick;
  logic       busy;
  logic       done;

  anim_sequencer #(
    .TICK_DIV  (T),
    .NUM_FRAMES(N),
    .LOOP_COUNT(L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_sleep (req_sleep),
    .req_eat   (req_eat),
    .req_play  (req_play),
    .anim_sel  (anim_sel),
    .step      (step),
    .frame_tick(frame_tick),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int stp;
    int tck;
    int bsy;
    int dne;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // Model: either idle (m_idle cycles since idle began with a fresh prescaler)
  // or playing m_anim, m_rel cycles after its START cycle; m_pend 0 = empty.
  int m_busy = 0;
  int m_anim = 0;
  int m_rel  = 0;
  int m_idle = 0;
  int m_pend = 0;

  function automatic int idle_step(input int r);
    int p;
`ifdef ANIM_PINGPONG_EN
    p = (r / T) % (2 * N - 2);
    return (p < N) ? p : (2 * N - 2 - p);
`else
    p = (r / T) % N;
    return p;
`endif
  endfunction

  function automatic exp_t model_out(input int c);
    exp_t x;
    x.cyc = c;
    if (m_busy == 0) begin
      x.sel = 0; x.bsy = 0; x.dne = 0;
      x.stp = idle_step(m_idle);
      x.tck = ((m_idle % T) == T - 1) ? 1 : 0;
    end else begin
      x.sel = m_anim; x.bsy = 1;
      if (m_rel == 0) begin
        x.stp = 0; x.tck = 0; x.dne = 0;
      end else if (m_rel <= NLT) begin
        x.stp = ((m_rel - 1) / T) % N;
        x.tck = ((m_rel % T) == 0) ? 1 : 0;
        x.dne = 0;
      end else begin
        x.stp = N - 1; x.tck = 0; x.dne = 1;
      end
    end
    return x;
  endfunction

  task automatic model_adv(input bit rn, input bit s, input bit e, input bit p);
    int rq;
    int cand;
    if (!rn) begin
      m_busy = 0; m_idle = 0; m_pend = 0;
      return;
    end
    rq = p ? 3 : (e ? 2 : (s ? 1 : 0));
    if (m_busy == 0 || m_rel == NLT + 1) begin
      cand = (rq > m_pend) ? rq : m_pend;
      if (cand != 0) begin
        if (m_pend != 0 && m_pend == cand) m_pend = 0;
        m_busy = 1; m_anim = cand; m_rel = 0;
      end else if (m_busy == 0) begin
        m_idle++;
      end else begin
        m_busy = 0; m_idle = 0;
      end
    end else if (m_rel == 0) begin
      m_rel = 1;
    end else begin
      if (rq > m_pend) m_pend = rq;
      m_rel++;
    end
  endtask

  task automatic cyc(input bit rn, input bit s, input bit e, input bit p);
    @(negedge clk);
    exp_q.push_back(model_out(cyc_n));
    rst = rn; req_sleep = s; req_eat = e; req_play = p;
    model_adv(rn, s, e, p);
    cyc_n++;
  endtask

  task automatic chk(input string name, input int got, input int want, input int c);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, c, got, want);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("anim_sel", int'(anim_sel), x.sel, x.cyc);
        chk("step", int'(step), x.stp, x.cyc);
        chk("frame_tick", int'(frame_tick), x.tck, x.cyc);
        chk("busy", int'(busy), x.bsy, x.cyc);
        chk("done", int'(done), x.dne, x.cyc);
      end
    end
  end

  initial begin
    int hold_cnt;
    bit [2:0] hold_vec;
    bit rn, s, e, p;
    rst = 1'b0; req_sleep = 1'b0; req_eat = 1'b0; req_play = 1'b0;
    hold_cnt = 0; hold_vec = 3'b000;
    repeat (2) @(negedge clk);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    // Long idle stretch covers the idle step wrap.
    repeat (2 * N * T + 6) cyc(1, 0, 0, 0);
    // Single sleep pulse, full run to done and back to idle.
    cyc(1, 1, 0, 0);
    repeat (NLT + 6) cyc(1, 0, 0, 0);
    // Simultaneous sleep + play: play wins; then sleep then eat while running.
    cyc(1, 1, 0, 1);
    repeat (6) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    repeat (5) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    repeat (2 * NLT + 10) cyc(1, 0, 0, 0);
    // Reset while running at step 7.
    cyc(1, 0, 1, 0);
    repeat (1 + 7 * T + 1) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (10) cyc(1, 0, 0, 0);
    // Randomized traffic: sparse pulses, held levels and rare resets.
    repeat (4000) begin
      rn = ($urandom_range(0, 599) != 0);
      if (hold_cnt > 0) begin
        {p, e, s} = hold_vec;
        hold_cnt--;
      end else if ($urandom_range(0, 199) == 0) begin
        hold_vec = 3'($urandom_range(1, 7));
        hold_cnt = $urandom_range(1, 20);
        {p, e, s} = hold_vec;
      end else begin
        s = ($urandom_range(0, 63) == 0);
        e = ($urandom_range(0, 63) == 0);
        p = ($urandom_range(0, 63) == 0);
      end
      cyc(rn, s, e, p);
    end
    @(negedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/anim_sequencer.md
Name: anim_sequencer

Overview:
- Controls the pet animation ROMs (sleep, eat, play, idle).
- Generates the frame tick with an internal prescaler, replacing the per-animation divided clocks.
- Chooses which animation drives the display. Idle loops by default; a requested animation plays for a fixed number of passes and then control returns to idle.
- Outputs anim_sel and step, which feed the display mux and the ROM step inputs.

Parameters:
- TICK_DIV, 33554432: clk cycles per frame tick. Must be >= 2. Prescaler width is $clog2(TICK_DIV).
- NUM_FRAMES, 16: frames per pass. Step counts 0..NUM_FRAMES-1. Step width is 4.
- LOOP_COUNT, 1: passes per requested animation. Must be >= 1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-low.
- req_sleep, input, 1: request the sleep animation. Level or pulse.
- req_eat, input, 1: request the eat animation.
- req_play, input, 1: request the play animation.
- anim_sel, output, 2: 0 = idle, 1 = sleep, 2 = eat, 3 = play.
- step, output, 4: current frame index.
- frame_tick, output, 1: one-cycle pulse at each frame boundary.
- busy, output, 1: high while a requested animation is in START, RUN or FINISH.
- done, output, 1: one-cycle pulse when a requested animation completes.

Behaviour:
- Reset (rst == 0 at posedge clk): state = IDLE, anim_sel = 0, step = 0, prescaler = 0, pass = 0, pending cleared, frame_tick = 0, busy = 0, done = 0. Reset applies in any state, including mid-RUN.
- Priority: play > eat > sleep.
- Prescaler:
  - Increments every cycle in IDLE and RUN.
  - frame_tick = 1 in the cycle prescaler == TICK_DIV-1; prescaler then wraps to 0.
  - Loaded with 0 and held in START and FINISH. frame_tick = 0 in those states.
- State IDLE:
  - anim_sel = 0, busy = 0.
  - step advances on each tick and wraps NUM_FRAMES-1 -> 0.
  - If any req is high, or pending is valid: pick the highest-priority source (pending competes at its own priority) and go to START next cycle.
- State START (1 cycle):
  - anim_sel = selected animation, step = 0, pass = 0, busy = 1, pending cleared if it was consumed.
  - Goes to RUN next cycle.
- State RUN:
  - On a tick with step < NUM_FRAMES-1: step increments.
  - On a tick with step == NUM_FRAMES-1 and pass < LOOP_COUNT-1: step = 0, pass increments.
  - On a tick with step == NUM_FRAMES-1 and pass == LOOP_COUNT-1: go to FINISH; step holds at NUM_FRAMES-1.
  - A request seen in RUN is latched into pending (one entry). A later higher-priority request overwrites it; a lower-priority one is dropped.
  - A request for the currently running animation is also latched, giving a replay.
- State FINISH (1 cycle):
  - done = 1, busy = 1.
  - If pending is valid, or a req is high this cycle, go to START. Otherwise go to IDLE with anim_sel = 0 and step = 0.
- Outputs are registered, with Moore timing: done and busy are decoded from the state register.
- Latency:
  - Request at cycle 0 -> START at cycle 1 -> RUN at cycle 2.
  - First tick at cycle 2 + TICK_DIV - 1.
  - FINISH at cycle 2 + NUM_FRAMES*LOOP_COUNT*TICK_DIV.

Optional Feature:
- Macro ANIM_PINGPONG_EN, which affects the IDLE loop only.
- Defined: step runs 0..15 then 15..0 repeatedly. Each endpoint frame is shown for exactly one tick, so the sequence is 14, 15, 14 (no repeat at the end). An internal direction bit resets to up.
- Undefined: the IDLE step wraps 15 -> 0.
- RUN behaviour is identical either way.

Test Plan:
1. TICK_DIV=4, LOOP_COUNT=1, req_sleep pulsed at cycle 0:
   - Cycle 1: busy=1, anim_sel=1, step=0.
   - frame_tick at cycles 5, 9, ..., 65; step=15 after cycle 61.
   - Cycle 66: done=1 for one cycle.
   - Cycle 67: IDLE, anim_sel=0, step=0.
2. req_sleep and req_play asserted in the same IDLE cycle -> anim_sel=3.
3. During play RUN: pulse req_sleep, then req_eat -> pending = eat. After done, START at the next cycle with anim_sel=2 and no IDLE cycle in between.
4. LOOP_COUNT=2, req_eat -> step wraps 15 -> 0 once; done at cycle 2 + 128 = 130.
5. rst=0 for 1 cycle mid-RUN (step=7) -> next cycle: IDLE, step=0, anim_sel=0, busy=0, pending cleared, no done pulse.
6. ANIM_PINGPONG_EN defined, IDLE, TICK_DIV=2 -> step sequence 0..15, 14..0, 1..., one value per tick.
